// File: rtl/mfc_frame_sched.sv
// Frame scheduler and single-port BRAM arbiter for the MFC sample buffer.
// Incoming samples fill a circular buffer; the framing engine reads overlapping frames out of it.
module mfc_frame_sched #(
    parameter int DWIDTH    = 30,
    parameter int AWIDTH    = 9,
    parameter int WORDS     = 400,
    parameter int FRAME_LEN = 240,
    parameter int HOP       = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              frm_start,
    output logic              frm_avail,
    output logic              frm_busy,
    output logic              o_valid,
    output logic [DWIDTH-1:0] o_data,
    output logic [AWIDTH-1:0] o_idx,
    output logic              o_last,
    output logic [AWIDTH:0]   fill,
    output logic              bram_write,
    output logic [AWIDTH-1:0] bram_addr,
    output logic [DWIDTH-1:0] bram_wdata,
    input  logic [DWIDTH-1:0] bram_rdata
);

    localparam int WORDS_M1 = WORDS - 1;
    localparam int LAST_IDX = FRAME_LEN - 1;
    localparam int ONE      = 1;

    localparam logic [AWIDTH:0]   L_WORDS    = WORDS[AWIDTH:0];
    localparam logic [AWIDTH:0]   L_FRAME    = FRAME_LEN[AWIDTH:0];
    localparam logic [AWIDTH:0]   L_HOP      = HOP[AWIDTH:0];
    localparam logic [AWIDTH:0]   L_FILL_ONE = ONE[AWIDTH:0];
    localparam logic [AWIDTH-1:0] L_PTR_ONE  = ONE[AWIDTH-1:0];
    localparam logic [AWIDTH-1:0] L_PTR_MAX  = WORDS_M1[AWIDTH-1:0];
    localparam logic [AWIDTH-1:0] L_LAST     = LAST_IDX[AWIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_wrPtr;
    logic [AWIDTH-1:0] r_base;
    logic [AWIDTH-1:0] r_idx;
    logic [AWIDTH:0]   r_fill;
    logic              r_oValid;
    logic              r_oLast;
    logic [AWIDTH-1:0] r_oIdx;

    logic              w_accept;
    logic              w_readIssue;
    logic              w_lastRead;
    logic              w_frmAvail;
    logic [AWIDTH:0]   w_addrSum;
    logic [AWIDTH:0]   w_addrWrap;
    logic [AWIDTH-1:0] w_rdAddr;
    logic [AWIDTH:0]   w_baseSum;
    logic [AWIDTH:0]   w_baseWrap;
    logic [AWIDTH-1:0] w_baseNext;
    logic [AWIDTH-1:0] w_wrPtrNext;

    // A write always wins the port; a pending read simply waits a cycle.
    assign w_accept    = s_valid && s_ready;
    assign w_readIssue = (r_state == READ) && !w_accept;
    assign w_lastRead  = (r_idx == L_LAST);
    assign w_frmAvail  = (r_state == IDLE) && (r_fill >= L_FRAME);

    assign w_addrSum  = {1'b0, r_base} + {1'b0, r_idx};
    assign w_addrWrap = w_addrSum - L_WORDS;
    assign w_rdAddr   = (w_addrSum >= L_WORDS) ? w_addrWrap[AWIDTH-1:0] : w_addrSum[AWIDTH-1:0];

    assign w_baseSum  = {1'b0, r_base} + L_HOP;
    assign w_baseWrap = w_baseSum - L_WORDS;
    assign w_baseNext = (w_baseSum >= L_WORDS) ? w_baseWrap[AWIDTH-1:0] : w_baseSum[AWIDTH-1:0];

    assign w_wrPtrNext = (r_wrPtr == L_PTR_MAX) ? '0 : r_wrPtr + L_PTR_ONE;

    assign s_ready    = (r_fill < L_WORDS);
    assign frm_avail  = w_frmAvail;
    assign frm_busy   = (r_state != IDLE);
    assign o_valid    = r_oValid;
    assign o_last     = r_oLast;
    assign o_idx      = r_oIdx;
    assign o_data     = bram_rdata;
    assign fill       = r_fill;
    assign bram_write = w_accept;
    assign bram_wdata = s_data;
    assign bram_addr  = w_readIssue ? w_rdAddr : r_wrPtr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_wrPtr  <= '0;
            r_base   <= '0;
            r_idx    <= '0;
            r_fill   <= '0;
            r_oValid <= 1'b0;
            r_oLast  <= 1'b0;
            r_oIdx   <= '0;
        end else begin
            if (w_accept) begin
                r_wrPtr <= w_wrPtrNext;
            end

            r_oValid <= w_readIssue;
            r_oLast  <= w_readIssue && w_lastRead;
            if (w_readIssue) begin
                r_oIdx <= r_idx;
            end

            case (r_state)
                IDLE: begin
                    if (frm_start && w_frmAvail) begin
                        r_state <= READ;
                        r_idx   <= '0;
                    end
                end
                READ: begin
                    if (w_readIssue) begin
                        r_idx <= r_idx + L_PTR_ONE;
                        if (w_lastRead) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    r_base  <= w_baseNext;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Releasing a hop and accepting a sample can coincide in the drain cycle.
            if (r_state == DRAIN) begin
                r_fill <= w_accept ? (r_fill + L_FILL_ONE - L_HOP) : (r_fill - L_HOP);
            end else if (w_accept) begin
                r_fill <= r_fill + L_FILL_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mfc_frame_sched.sv
// Directed bench for mfc_frame_sched with a registered-read BRAM model.
// Ramp data lets every frame sample be predicted from its position in the sample stream.
module tb_mfc_frame_sched;

    localparam int DWIDTH    = 30;
    localparam int AWIDTH    = 9;
    localparam int WORDS     = 400;
    localparam int FRAME_LEN = 240;
    localparam int HOP       = 80;

    logic              clk;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              frm_start;
    logic              frm_avail;
    logic              frm_busy;
    logic              o_valid;
    logic [DWIDTH-1:0] o_data;
    logic [AWIDTH-1:0] o_idx;
    logic              o_last;
    logic [AWIDTH:0]   fill;
    logic              bram_write;
    logic [AWIDTH-1:0] bram_addr;
    logic [DWIDTH-1:0] bram_wdata;
    logic [DWIDTH-1:0] bram_rdata;

    logic [DWIDTH-1:0] mem [0:WORDS-1];

    int errors;
    int checks;
    int valBase;
    int wrCount;
    int frameS;
    int expFill;
    int got;
    int cyc;

    mfc_frame_sched #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .WORDS(WORDS), .FRAME_LEN(FRAME_LEN), .HOP(HOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .frm_start(frm_start), .frm_avail(frm_avail), .frm_busy(frm_busy),
        .o_valid(o_valid), .o_data(o_data), .o_idx(o_idx), .o_last(o_last),
        .fill(fill),
        .bram_write(bram_write), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_write) mem[bram_addr] <= bram_wdata;
        bram_rdata <= mem[bram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DWIDTH'(valBase + wrCount);
            tick();
            wrCount++;
            expFill++;
        end
        s_valid = 1'b0;
    endtask

    // One full frame; writeEvery>0 offers a sample on every writeEvery-th cycle.
    task automatic runFrame(input int writeEvery);
        int n;
        int c;
        int nW;
        bit wrote;
        n  = 0;
        c  = 0;
        nW = 0;
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        checkOutput("frameBusy", {31'b0, frm_busy}, 1);
        checkOutput("frameFirstAddr", {23'b0, bram_addr}, frameS % WORDS);
        checkOutput("frameNoValidYet", {31'b0, o_valid}, 0);
        while (n < FRAME_LEN && c < 1000) begin
            wrote = (writeEvery != 0) && ((c % writeEvery) == writeEvery - 1);
            if (wrote) begin
                s_valid = 1'b1;
                s_data  = DWIDTH'(valBase + wrCount);
                wrCount++;
                nW++;
                #1;
                checkOutput("writeGrant", {31'b0, bram_write}, 1);
            end else begin
                s_valid = 1'b0;
            end
            tick();
            c++;
            checkOutput("validPattern", {31'b0, o_valid}, wrote ? 0 : 1);
            if (o_valid === 1'b1) begin
                checkOutput("frameIdx", {23'b0, o_idx}, n);
                checkOutput("frameData", {2'b0, o_data}, valBase + frameS + n);
                checkOutput("frameLast", {31'b0, o_last}, (n == FRAME_LEN - 1) ? 1 : 0);
                n++;
            end
        end
        s_valid = 1'b0;
        checkOutput("frameComplete", n, FRAME_LEN);
        tick();
        expFill = expFill + nW - HOP;
        frameS  = frameS + HOP;
        checkOutput("postBusy", {31'b0, frm_busy}, 0);
        checkOutput("postFill", {22'b0, fill}, expFill);
        checkOutput("postAvail", {31'b0, frm_avail}, (expFill >= FRAME_LEN) ? 1 : 0);
        checkOutput("postReady", {31'b0, s_ready}, (expFill < WORDS) ? 1 : 0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        valBase   = 0;
        wrCount   = 0;
        frameS    = 0;
        expFill   = 0;
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        frm_start = 1'b0;

        tick();
        tick();
        $display("[TB] reset state");
        checkOutput("rstValid", {31'b0, o_valid}, 0);
        checkOutput("rstLast", {31'b0, o_last}, 0);
        checkOutput("rstIdx", {23'b0, o_idx}, 0);
        checkOutput("rstBusy", {31'b0, frm_busy}, 0);
        checkOutput("rstAvail", {31'b0, frm_avail}, 0);
        checkOutput("rstReady", {31'b0, s_ready}, 1);
        checkOutput("rstWrite", {31'b0, bram_write}, 0);
        checkOutput("rstAddr", {23'b0, bram_addr}, 0);
        checkOutput("rstFill", {22'b0, fill}, 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] fill threshold");
        applyStimulus(239);
        checkOutput("fill239", {22'b0, fill}, 239);
        checkOutput("avail239", {31'b0, frm_avail}, 0);
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        checkOutput("earlyStartIgnored", {31'b0, frm_busy}, 0);
        applyStimulus(1);
        checkOutput("fill240", {22'b0, fill}, 240);
        checkOutput("avail240", {31'b0, frm_avail}, 1);

        $display("[TB] full buffer backpressure");
        applyStimulus(160);
        checkOutput("fillFull", {22'b0, fill}, 400);
        checkOutput("readyFull", {31'b0, s_ready}, 0);
        s_valid = 1'b1;
        s_data  = DWIDTH'(999);
        #1;
        checkOutput("heldNoWrite", {31'b0, bram_write}, 0);
        checkOutput("heldAddr", {23'b0, bram_addr}, 0);
        tick();
        s_valid = 1'b0;
        checkOutput("heldFill", {22'b0, fill}, 400);

        $display("[TB] frames without writes");
        runFrame(0);
        checkOutput("fillAfterFrame1", {22'b0, fill}, 320);
        runFrame(0);

        $display("[TB] frame with interleaved writes");
        runFrame(3);

        $display("[TB] wrap-around frames");
        applyStimulus(WORDS - expFill);
        checkOutput("refillFull", {22'b0, fill}, 400);
        runFrame(0);
        runFrame(0);

        $display("[TB] reset mid-frame");
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        checkOutput("baseWrappedToZero", {23'b0, bram_addr}, 0);
        got = 0;
        cyc = 0;
        while (got < 100 && cyc < 500) begin
            tick();
            cyc++;
            if (o_valid === 1'b1) got++;
        end
        checkOutput("reachIdx100", got, 100);
        rst_n = 1'b0;
        tick();
        checkOutput("abortValid", {31'b0, o_valid}, 0);
        checkOutput("abortBusy", {31'b0, frm_busy}, 0);
        checkOutput("abortFill", {22'b0, fill}, 0);
        checkOutput("abortReady", {31'b0, s_ready}, 1);
        rst_n = 1'b1;
        tick();
        checkOutput("abortNoMoreValid", {31'b0, o_valid}, 0);
        frm_start = 1'b1;
        tick();
        frm_start = 1'b0;
        checkOutput("startAfterResetIgnored", {31'b0, frm_busy}, 0);

        valBase = 5000;
        wrCount = 0;
        frameS  = 0;
        expFill = 0;
        applyStimulus(239);
        checkOutput("availAfterReset239", {31'b0, frm_avail}, 0);
        applyStimulus(1);
        checkOutput("availAfterReset240", {31'b0, frm_avail}, 1);
        runFrame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
